// File: rtl/msrv32_csr_pkg.sv
// ----------------------------------------------------------------------------
// msrv32_csr_pkg
// Shared constants for the machine-mode CSR file: CSR addresses, access-op
// encodings, mstatus/mie/mip bit positions, mtvec mode codes, the misa value
// and the read-modify-write merge used by every CSR write path.
// No ports (package).
// ----------------------------------------------------------------------------
package msrv32_csr_pkg;

   // CSR addresses
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   // access op encodings
   typedef enum logic [1:0] {
      CSR_OP_NONE  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   // mstatus bit positions
   localparam int MSTATUS_MIE_BIT    = 3;
   localparam int MSTATUS_MPIE_BIT   = 7;
   localparam int MSTATUS_MPP_LO_BIT = 11;
   localparam int MSTATUS_MPP_HI_BIT = 12;

   // mie / mip bit positions (same layout)
   localparam int MIX_MEI_BIT = 11;
   localparam int MIX_MTI_BIT = 7;
   localparam int MIX_MSI_BIT = 3;

   // mtvec mode codes (only these two are ever stored)
   typedef enum logic [1:0] {
      MTVEC_DIRECT   = 2'b00,
      MTVEC_VECTORED = 2'b01
   } mtvec_mode_e;

   localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

   // New CSR value for a write/set/clear access on top of the old value.
   function automatic logic [31:0] csr_merge(input logic [1:0]  op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] wdata);
      logic [31:0] r;
      case (op)
         CSR_OP_WRITE: r = wdata;
         CSR_OP_SET:   r = old_val | wdata;
         CSR_OP_CLEAR: r = old_val & ~wdata;
         default:      r = old_val;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/msrv32_trap_csr_file_if.sv
// ----------------------------------------------------------------------------
// msrv32_trap_csr_file_if
// Software CSR access bus between the instruction datapath and the CSR file.
//   csr_addr_in   [11:0]  CSR address
//   csr_op_in     [1:0]   00 none, 01 write, 10 set, 11 clear
//   csr_wdata_in  [31:0]  write/set/clear operand
//   csr_data_out  [31:0]  combinational read data
//   illegal_csr_out       bad access flag
// Modports: master (requester), slave (CSR file).
// ----------------------------------------------------------------------------
interface msrv32_trap_csr_file_if;
   logic [11:0] csr_addr_in;
   logic [1:0]  csr_op_in;
   logic [31:0] csr_wdata_in;
   logic [31:0] csr_data_out;
   logic        illegal_csr_out;

   modport master (output csr_addr_in, csr_op_in, csr_wdata_in,
                   input  csr_data_out, illegal_csr_out);
   modport slave  (input  csr_addr_in, csr_op_in, csr_wdata_in,
                   output csr_data_out, illegal_csr_out);
endinterface

// File: rtl/msrv32_csr_counter.sv
// ----------------------------------------------------------------------------
// msrv32_csr_counter
// 64-bit machine counter with increment enable and 32-bit half writes.
//   clock, reset_in      clock, synchronous active-high reset
//   inc_in               count up by one this cycle
//   wr_lo_in / wr_hi_in  load wdata_in into the low / high half
//   wdata_in  [31:0]     half-word write data
//   count_out [63:0]     current count
// A half write freezes the whole counter for that cycle (no increment and no
// carry into the other half); it wraps naturally from 2^64-1 to 0.
// ----------------------------------------------------------------------------
module msrv32_csr_counter (
   input  logic        clock,
   input  logic        reset_in,
   input  logic        inc_in,
   input  logic        wr_lo_in,
   input  logic        wr_hi_in,
   input  logic [31:0] wdata_in,
   output logic [63:0] count_out
);

   always_ff @(posedge clock) begin
      if (reset_in)
         count_out <= '0;
      else if (wr_lo_in)
         count_out[31:0] <= wdata_in;
      else if (wr_hi_in)
         count_out[63:32] <= wdata_in;
      else if (inc_in)
         count_out <= count_out + 64'd1;
   end

endmodule

// File: rtl/msrv32_trap_csr_file.sv
// ----------------------------------------------------------------------------
// msrv32_trap_csr_file
// Machine-mode CSR file with trap entry/return handling.
// Ports:
//   clock, reset_in            clock, synchronous active-high reset
//   csr_bus (slave)            software CSR access (see msrv32_trap_csr_file_if)
//   set_epc_in                 trap entry: capture mepc / mtval
//   set_cause_in, i_or_e_in,
//   cause_in[3:0]              load mcause
//   mie_clear_in / mie_set_in  trap entry / mret handling of MIE/MPIE
//   instret_inc_in             instruction retired
//   misaligned_exception_in    mtval takes iadder_in instead of 0
//   pc_in, iadder_in [31:0]    faulting PC / faulting address
//   e/t/s_irq_in               raw interrupt lines (registered into mip)
//   mie_out, meie/mtie/msie_out, meip/mtip/msip_out  interrupt state
//   epc_out, trap_address_out  mret target / trap vector
// Build option: define MSRV32_COUNTERS_EN to add the 64-bit mcycle and
// minstret counters; without it their addresses are unimplemented.
// ----------------------------------------------------------------------------
module msrv32_trap_csr_file
   import msrv32_csr_pkg::*;
(
   input  logic                         clock,
   input  logic                         reset_in,
   msrv32_trap_csr_file_if.slave        csr_bus,
   input  logic                         set_epc_in,
   input  logic                         set_cause_in,
   input  logic                         i_or_e_in,
   input  logic                         mie_clear_in,
   input  logic                         mie_set_in,
   input  logic                         instret_inc_in,
   input  logic                         misaligned_exception_in,
   input  logic [3:0]                   cause_in,
   input  logic [31:0]                  pc_in,
   input  logic [31:0]                  iadder_in,
   input  logic                         e_irq_in,
   input  logic                         t_irq_in,
   input  logic                         s_irq_in,
   output logic                         mie_out,
   output logic                         meie_out,
   output logic                         mtie_out,
   output logic                         msie_out,
   output logic                         meip_out,
   output logic                         mtip_out,
   output logic                         msip_out,
   output logic [31:0]                  epc_out,
   output logic [31:0]                  trap_address_out
);

   logic [11:0] addr;
   logic [1:0]  op;

   logic        mstatus_mie, mstatus_mpie;
   logic        mie_meie, mie_mtie, mie_msie;
   logic        mip_meip, mip_mtip, mip_msip;
   logic [29:0] mtvec_base;
   mtvec_mode_e mtvec_mode;
   logic [31:0] mscratch, mepc, mcause, mtval;

   logic [31:0] mstatus_rd, mie_rd, mip_rd;
   logic [31:0] rd_raw, wr_val;
   logic        addr_valid, illegal, wr_en;
   logic        unused_inputs;

   assign addr = csr_bus.csr_addr_in;
   assign op   = csr_bus.csr_op_in;

`ifdef MSRV32_COUNTERS_EN
   logic [63:0] mcycle, minstret;

   msrv32_csr_counter u_mcycle (
      .clock     (clock),
      .reset_in  (reset_in),
      .inc_in    (1'b1),
      .wr_lo_in  (wr_en && addr == CSR_MCYCLE),
      .wr_hi_in  (wr_en && addr == CSR_MCYCLEH),
      .wdata_in  (wr_val),
      .count_out (mcycle)
   );

   msrv32_csr_counter u_minstret (
      .clock     (clock),
      .reset_in  (reset_in),
      .inc_in    (instret_inc_in),
      .wr_lo_in  (wr_en && addr == CSR_MINSTRET),
      .wr_hi_in  (wr_en && addr == CSR_MINSTRETH),
      .wdata_in  (wr_val),
      .count_out (minstret)
   );

   assign unused_inputs = &{1'b0, pc_in[1:0]};
`else
   assign unused_inputs = &{1'b0, pc_in[1:0], instret_inc_in};
`endif

   // packed views of the field-level registers
   always_comb begin
      mstatus_rd = '0;
      mstatus_rd[MSTATUS_MPP_HI_BIT:MSTATUS_MPP_LO_BIT] = 2'b11;
      mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie;
      mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie;

      mie_rd = '0;
      mie_rd[MIX_MEI_BIT] = mie_meie;
      mie_rd[MIX_MTI_BIT] = mie_mtie;
      mie_rd[MIX_MSI_BIT] = mie_msie;

      mip_rd = '0;
      mip_rd[MIX_MEI_BIT] = mip_meip;
      mip_rd[MIX_MTI_BIT] = mip_mtip;
      mip_rd[MIX_MSI_BIT] = mip_msip;
   end

   // read mux; also flags whether the address exists at all
   always_comb begin
      rd_raw     = '0;
      addr_valid = 1'b1;
      case (addr)
         CSR_MSTATUS:  rd_raw = mstatus_rd;
         CSR_MISA:     rd_raw = MISA_VALUE;
         CSR_MIE:      rd_raw = mie_rd;
         CSR_MTVEC:    rd_raw = {mtvec_base, mtvec_mode};
         CSR_MSCRATCH: rd_raw = mscratch;
         CSR_MEPC:     rd_raw = mepc;
         CSR_MCAUSE:   rd_raw = mcause;
         CSR_MTVAL:    rd_raw = mtval;
         CSR_MIP:      rd_raw = mip_rd;
         CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: rd_raw = '0;
`ifdef MSRV32_COUNTERS_EN
         CSR_MCYCLE:    rd_raw = mcycle[31:0];
         CSR_MCYCLEH:   rd_raw = mcycle[63:32];
         CSR_MINSTRET:  rd_raw = minstret[31:0];
         CSR_MINSTRETH: rd_raw = minstret[63:32];
`endif
         default:       addr_valid = 1'b0;
      endcase
   end

   // addr[11:10]==11 is the read-only CSR space: any access op there is bad
   assign illegal = (op != CSR_OP_NONE) && (!addr_valid || addr[11:10] == 2'b11);
   assign wr_en   = (op != CSR_OP_NONE) && !illegal;
   assign wr_val  = csr_merge(op, rd_raw, csr_bus.csr_wdata_in);

   assign csr_bus.csr_data_out    = illegal ? 32'd0 : rd_raw;
   assign csr_bus.illegal_csr_out = illegal;

   // Trap-control updates sit ahead of the software write in each if-chain so
   // that a same-cycle software write to the same CSR is dropped.
   always_ff @(posedge clock) begin
      if (reset_in) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_meie     <= 1'b0;
         mie_mtie     <= 1'b0;
         mie_msie     <= 1'b0;
         mip_meip     <= 1'b0;
         mip_mtip     <= 1'b0;
         mip_msip     <= 1'b0;
         mtvec_base   <= '0;
         mtvec_mode   <= MTVEC_DIRECT;
         mscratch     <= '0;
         mepc         <= '0;
         mcause       <= '0;
         mtval        <= '0;
      end else begin
         // clear wins over set when both are raised
         if (mie_clear_in) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (mie_set_in) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (wr_en && addr == CSR_MSTATUS) begin
            mstatus_mie  <= wr_val[MSTATUS_MIE_BIT];
            mstatus_mpie <= wr_val[MSTATUS_MPIE_BIT];
         end

         if (wr_en && addr == CSR_MIE) begin
            mie_meie <= wr_val[MIX_MEI_BIT];
            mie_mtie <= wr_val[MIX_MTI_BIT];
            mie_msie <= wr_val[MIX_MSI_BIT];
         end

         // base always written; mode only for 00/01 (i.e. bit 1 clear)
         if (wr_en && addr == CSR_MTVEC) begin
            mtvec_base <= wr_val[31:2];
            if (!wr_val[1])
               mtvec_mode <= mtvec_mode_e'(wr_val[1:0]);
         end

         if (wr_en && addr == CSR_MSCRATCH)
            mscratch <= wr_val;

         if (set_epc_in) begin
            mepc  <= {pc_in[31:2], 2'b00};
            mtval <= misaligned_exception_in ? iadder_in : 32'd0;
         end else begin
            if (wr_en && addr == CSR_MEPC)
               mepc <= wr_val;
            if (wr_en && addr == CSR_MTVAL)
               mtval <= wr_val;
         end

         if (set_cause_in)
            mcause <= {i_or_e_in, 27'd0, cause_in};
         else if (wr_en && addr == CSR_MCAUSE)
            mcause <= wr_val;

         mip_meip <= e_irq_in;
         mip_mtip <= t_irq_in;
         mip_msip <= s_irq_in;
      end
   end

   // vectored mode only redirects interrupts; exceptions use the base
   assign trap_address_out = (mtvec_mode == MTVEC_VECTORED && mcause[31])
                           ? {mtvec_base, 2'b00} + {26'd0, mcause[3:0], 2'b00}
                           : {mtvec_base, 2'b00};

   assign epc_out  = mepc;
   assign mie_out  = mstatus_mie;
   assign meie_out = mie_meie;
   assign mtie_out = mie_mtie;
   assign msie_out = mie_msie;
   assign meip_out = mip_meip;
   assign mtip_out = mip_mtip;
   assign msip_out = mip_msip;

endmodule

// File: tb/tb_msrv32_trap_csr_file.sv
// ----------------------------------------------------------------------------
// tb_msrv32_trap_csr_file
// Self-checking bench for msrv32_trap_csr_file: directed scenarios plus a
// randomized run against a word-level reference model of the CSR file.
// Honours MSRV32_COUNTERS_EN the same way the design does.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_msrv32_trap_csr_file;

`ifdef MSRV32_COUNTERS_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_in;
   logic        set_epc_in, set_cause_in, i_or_e_in, mie_clear_in, mie_set_in;
   logic        instret_inc_in, misaligned_exception_in;
   logic [3:0]  cause_in;
   logic [31:0] pc_in, iadder_in;
   logic        e_irq_in, t_irq_in, s_irq_in;
   logic        mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out, msip_out;
   logic [31:0] epc_out, trap_address_out;

   int vectors = 0;
   int errors  = 0;

   msrv32_trap_csr_file_if csr_bus();

   msrv32_trap_csr_file dut (
      .clock                   (clock),
      .reset_in                (reset_in),
      .csr_bus                 (csr_bus),
      .set_epc_in              (set_epc_in),
      .set_cause_in            (set_cause_in),
      .i_or_e_in               (i_or_e_in),
      .mie_clear_in            (mie_clear_in),
      .mie_set_in              (mie_set_in),
      .instret_inc_in          (instret_inc_in),
      .misaligned_exception_in (misaligned_exception_in),
      .cause_in                (cause_in),
      .pc_in                   (pc_in),
      .iadder_in               (iadder_in),
      .e_irq_in                (e_irq_in),
      .t_irq_in                (t_irq_in),
      .s_irq_in                (s_irq_in),
      .mie_out                 (mie_out),
      .meie_out                (meie_out),
      .mtie_out                (mtie_out),
      .msie_out                (msie_out),
      .meip_out                (meip_out),
      .mtip_out                (mtip_out),
      .msip_out                (msip_out),
      .epc_out                 (epc_out),
      .trap_address_out        (trap_address_out)
   );

   always #5 clock = ~clock;

   // ---------------- reference model (whole 32-bit CSR words) ----------------
   logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
   logic [63:0] m_mcycle, m_minstret;

   function automatic bit m_impl(input logic [11:0] a);
      case (a)
         12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
         12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
         12'hB00, 12'hB80, 12'hB02, 12'hB82: return CNT_EN;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h301: return 32'h4000_0100;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return m_mip;
         12'hB00: return CNT_EN ? m_mcycle[31:0]    : 32'd0;
         12'hB80: return CNT_EN ? m_mcycle[63:32]   : 32'd0;
         12'hB02: return CNT_EN ? m_minstret[31:0]  : 32'd0;
         12'hB82: return CNT_EN ? m_minstret[63:32] : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit m_illegal(input logic [11:0] a, input logic [1:0] o);
      return (o != 2'b00) && (!m_impl(a) || a[11:10] == 2'b11);
   endfunction

   // advance the model by one clock edge using the currently driven inputs
   task automatic m_step();
      logic [11:0] a;
      logic [1:0]  o;
      logic [31:0] w, old, nv, pre_mstatus;
      bit          wr;
      a = csr_bus.csr_addr_in;
      o = csr_bus.csr_op_in;
      w = csr_bus.csr_wdata_in;
      if (reset_in) begin
         m_mstatus = 32'h0000_1800;
         {m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip} = '0;
         m_mcycle = '0;
         m_minstret = '0;
         return;
      end
      pre_mstatus = m_mstatus;
      wr  = (o != 2'b00) && !m_illegal(a, o);
      old = m_read(a);
      nv  = (o == 2'b01) ? w : (o == 2'b10) ? (old | w) : (old & ~w);
      if (!(wr && (a == 12'hB00 || a == 12'hB80))) m_mcycle = m_mcycle + 1;
      if (instret_inc_in && !(wr && (a == 12'hB02 || a == 12'hB82))) m_minstret = m_minstret + 1;
      if (wr) begin
         case (a)
            12'h300: m_mstatus = (m_mstatus & ~32'h88) | (nv & 32'h88);
            12'h304: m_mie = nv & 32'h888;
            12'h305: m_mtvec = {nv[31:2], (nv[1:0] <= 2'b01) ? nv[1:0] : m_mtvec[1:0]};
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv;
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
            12'hB00: m_mcycle[31:0] = nv;
            12'hB80: m_mcycle[63:32] = nv;
            12'hB02: m_minstret[31:0] = nv;
            12'hB82: m_minstret[63:32] = nv;
            default: ;
         endcase
      end
      // hardware trap updates overwrite whatever software did this cycle
      if (set_epc_in) begin
         m_mepc  = pc_in & 32'hFFFF_FFFC;
         m_mtval = misaligned_exception_in ? iadder_in : 32'd0;
      end
      if (set_cause_in) m_mcause = {i_or_e_in, 27'd0, cause_in};
      if (mie_clear_in)
         m_mstatus = 32'h1800 | (pre_mstatus[3] ? 32'h80 : 32'h0);
      else if (mie_set_in)
         m_mstatus = 32'h1880 | (pre_mstatus[7] ? 32'h8 : 32'h0);
      m_mip = (e_irq_in ? 32'h800 : 32'h0) | (t_irq_in ? 32'h80 : 32'h0) | (s_irq_in ? 32'h8 : 32'h0);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      {set_epc_in, set_cause_in, i_or_e_in, mie_clear_in, mie_set_in} = '0;
      {instret_inc_in, misaligned_exception_in, e_irq_in, t_irq_in, s_irq_in} = '0;
      cause_in  = '0;
      pc_in     = '0;
      iadder_in = '0;
      csr_bus.csr_addr_in  = '0;
      csr_bus.csr_op_in    = '0;
      csr_bus.csr_wdata_in = '0;
   endtask

   task automatic drive(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w);
      csr_bus.csr_addr_in  = a;
      csr_bus.csr_op_in    = o;
      csr_bus.csr_wdata_in = w;
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_in = 1'b1;
      tick();
      tick();
      reset_in = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [11:0] addrs [14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0};
      logic [31:0] exps  [14] = '{32'h1800, 32'h4000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      logic [8:0]  outs;
      do_reset();
      for (int k = 0; k < 14; k++) begin
         drive(addrs[k], 2'b00, 32'hFFFF_FFFF);
         vectors++;
         if (csr_bus.csr_data_out !== exps[k] || csr_bus.illegal_csr_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_read addr=%h got data=%h illegal=%b want data=%h illegal=0",
                     addrs[k], csr_bus.csr_data_out, csr_bus.illegal_csr_out, exps[k]);
         end
      end
      outs = {mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out, msip_out,
              |epc_out, |trap_address_out};
      vectors++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 000000000", outs);
      end
      // reset must beat a same-cycle write and trap
      drive(12'h340, 2'b01, 32'hAA);
      tick();
      drive(12'h340, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'hAA) begin
         errors++;
         $display("FAIL mscratch_write got %h want 000000aa", csr_bus.csr_data_out);
      end
      reset_in = 1'b1;
      set_epc_in = 1'b1; set_cause_in = 1'b1; pc_in = 32'h1234; cause_in = 4'h5;
      drive(12'h340, 2'b01, 32'h55);
      tick();
      reset_in = 1'b0;
      idle_inputs();
      drive(12'h340, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h0 || epc_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_override got mscratch=%h epc=%h want 0 0", csr_bus.csr_data_out, epc_out);
      end
      drive(12'h342, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_override_mcause got %h want 0", csr_bus.csr_data_out);
      end
   endtask

   task automatic test_trap();
      do_reset();
      drive(12'h304, 2'b01, 32'h800); tick();
      drive(12'h300, 2'b10, 32'h8);   tick();
      drive(12'h305, 2'b01, 32'h1001); tick();
      drive(12'h000, 2'b00, 0);
      vectors++;
      if ({mie_out, meie_out, trap_address_out} !== {2'b11, 32'h1000}) begin
         errors++;
         $display("FAIL trap_setup got mie=%b meie=%b taddr=%h want 1 1 00001000",
                  mie_out, meie_out, trap_address_out);
      end
      set_epc_in = 1'b1; set_cause_in = 1'b1; mie_clear_in = 1'b1;
      i_or_e_in = 1'b1; cause_in = 4'hB; pc_in = 32'h106;
      tick();
      idle_inputs();
      drive(12'h342, 2'b00, 0);
      vectors++;
      if (epc_out !== 32'h104 || csr_bus.csr_data_out !== 32'h8000_000B) begin
         errors++;
         $display("FAIL trap_epc_cause got epc=%h mcause=%h want 00000104 8000000b",
                  epc_out, csr_bus.csr_data_out);
      end
      drive(12'h300, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h1880 || mie_out !== 1'b0) begin
         errors++;
         $display("FAIL trap_mstatus got %h mie=%b want 00001880 0", csr_bus.csr_data_out, mie_out);
      end
      drive(12'h343, 2'b00, 0);
      vectors++;
      if (trap_address_out !== 32'h102C || csr_bus.csr_data_out !== 32'h0) begin
         errors++;
         $display("FAIL trap_vector got taddr=%h mtval=%h want 0000102c 0",
                  trap_address_out, csr_bus.csr_data_out);
      end
   endtask

   task automatic test_mret();
      // follows test_trap state: MIE=0, MPIE=1
      mie_set_in = 1'b1; set_epc_in = 1'b1; pc_in = 32'h200;
      drive(12'h341, 2'b01, 32'h55);
      tick();
      idle_inputs();
      drive(12'h300, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h1888 || mie_out !== 1'b1 || epc_out !== 32'h200) begin
         errors++;
         $display("FAIL mret got mstatus=%h mie=%b epc=%h want 00001888 1 00000200",
                  csr_bus.csr_data_out, mie_out, epc_out);
      end
      set_epc_in = 1'b1; misaligned_exception_in = 1'b1; iadder_in = 32'h1235; pc_in = 32'h303;
      tick();
      idle_inputs();
      drive(12'h343, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h1235 || epc_out !== 32'h300) begin
         errors++;
         $display("FAIL misaligned got mtval=%h epc=%h want 00001235 00000300",
                  csr_bus.csr_data_out, epc_out);
      end
      mie_clear_in = 1'b1; mie_set_in = 1'b1;
      tick();
      idle_inputs();
      drive(12'h300, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h1880) begin
         errors++;
         $display("FAIL clear_and_set got %h want 00001880", csr_bus.csr_data_out);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      drive(12'hF11, 2'b01, 32'hFFFF_FFFF);
      vectors++;
      if (csr_bus.illegal_csr_out !== 1'b1 || csr_bus.csr_data_out !== 32'h0) begin
         errors++;
         $display("FAIL illegal_ro got illegal=%b data=%h want 1 0",
                  csr_bus.illegal_csr_out, csr_bus.csr_data_out);
      end
      tick();
      drive(12'h7C0, 2'b10, 32'h1);
      vectors++;
      if (csr_bus.illegal_csr_out !== 1'b1) begin
         errors++;
         $display("FAIL illegal_unimpl got %b want 1", csr_bus.illegal_csr_out);
      end
      drive(12'h344, 2'b01, 32'hFFFF_FFFF);
      vectors++;
      if (csr_bus.illegal_csr_out !== 1'b0) begin
         errors++;
         $display("FAIL mip_write_flag got %b want 0", csr_bus.illegal_csr_out);
      end
      tick();
      drive(12'h344, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h0 || csr_bus.illegal_csr_out !== 1'b0) begin
         errors++;
         $display("FAIL mip_ro got %h want 0", csr_bus.csr_data_out);
      end
      drive(12'h305, 2'b01, 32'h203); tick();
      drive(12'h305, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h200) begin
         errors++;
         $display("FAIL mtvec_warl got %h want 00000200", csr_bus.csr_data_out);
      end
      drive(12'h305, 2'b01, 32'h1001); tick();
      drive(12'h305, 2'b01, 32'h2002); tick();
      drive(12'h305, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h2001) begin
         errors++;
         $display("FAIL mtvec_keep_mode got %h want 00002001", csr_bus.csr_data_out);
      end
      drive(12'h300, 2'b01, 32'hFFFF_FFFF); tick();
      drive(12'h300, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h1888) begin
         errors++;
         $display("FAIL mstatus_mask got %h want 00001888", csr_bus.csr_data_out);
      end
   endtask

`ifdef MSRV32_COUNTERS_EN
   task automatic test_counters();
      do_reset();
      drive(12'hB00, 2'b01, 32'hFFFF_FFFF); tick();
      drive(12'hB80, 2'b01, 32'hFFFF_FFFF); tick();
      drive(12'hB00, 2'b00, 0);
      tick();
      tick();
      vectors++;
      if (csr_bus.csr_data_out !== 32'h1) begin
         errors++;
         $display("FAIL mcycle_wrap_lo got %h want 00000001", csr_bus.csr_data_out);
      end
      drive(12'hB80, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h0) begin
         errors++;
         $display("FAIL mcycle_wrap_hi got %h want 0", csr_bus.csr_data_out);
      end
      do_reset();
      instret_inc_in = 1'b1;
      tick(); tick(); tick();
      instret_inc_in = 1'b0;
      drive(12'hB02, 2'b00, 0);
      vectors++;
      if (csr_bus.csr_data_out !== 32'h3) begin
         errors++;
         $display("FAIL minstret got %h want 00000003", csr_bus.csr_data_out);
      end
   endtask
`else
   task automatic test_counters();
      do_reset();
      drive(12'hB00, 2'b01, 32'h5);
      vectors++;
      if (csr_bus.illegal_csr_out !== 1'b1 || csr_bus.csr_data_out !== 32'h0) begin
         errors++;
         $display("FAIL counter_absent got illegal=%b data=%h want 1 0",
                  csr_bus.illegal_csr_out, csr_bus.csr_data_out);
      end
      drive(12'hB82, 2'b00, 0);
      vectors++;
      if (csr_bus.illegal_csr_out !== 1'b0 || csr_bus.csr_data_out !== 32'h0) begin
         errors++;
         $display("FAIL counter_absent_read got illegal=%b data=%h want 0 0",
                  csr_bus.illegal_csr_out, csr_bus.csr_data_out);
      end
   endtask
`endif

   task automatic test_random();
      logic [11:0]  pool [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'hF11, 12'hF14, 12'hB00, 12'hB80, 12'hB02,
                                  12'hB82, 12'h305, 12'h300, 12'h342, 12'h7C0, 12'hC00};
      logic [103:0] got, exp;
      logic [31:0]  taddr;
      logic [11:0]  a;
      logic [1:0]   o;
      for (int i = 0; i < 600; i++) begin
         reset_in = (i == 0) || ($urandom_range(0, 49) == 0);
         a = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095)) : pool[$urandom_range(0, 19)];
         o = 2'($urandom_range(0, 3));
         csr_bus.csr_addr_in  = a;
         csr_bus.csr_op_in    = o;
         csr_bus.csr_wdata_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         set_epc_in   = ($urandom_range(0, 7) == 0);
         set_cause_in = ($urandom_range(0, 7) == 0);
         mie_clear_in = ($urandom_range(0, 7) == 0);
         mie_set_in   = ($urandom_range(0, 7) == 0);
         i_or_e_in    = 1'($urandom);
         cause_in     = 4'($urandom);
         misaligned_exception_in = 1'($urandom);
         instret_inc_in = 1'($urandom);
         {e_irq_in, t_irq_in, s_irq_in} = 3'($urandom);
         pc_in     = $urandom;
         iadder_in = $urandom;
         #1;
         if (!reset_in || i > 0) begin
            taddr = (m_mtvec[1:0] == 2'b01 && m_mcause[31]) ? (m_mtvec & ~32'h3) + 32'(m_mcause[3:0]) * 4
                                                            : (m_mtvec & ~32'h3);
            exp = {m_illegal(a, o) ? 32'd0 : m_read(a), 1'(m_illegal(a, o)), m_mepc, taddr,
                   m_mstatus[3], m_mie[11], m_mie[7], m_mie[3], m_mip[11], m_mip[7], m_mip[3]};
            got = {csr_bus.csr_data_out, csr_bus.illegal_csr_out, epc_out, trap_address_out,
                   mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out, msip_out};
            if (i > 0) begin
               vectors++;
               if (got !== exp) begin
                  errors++;
                  $display("FAIL random[%0d] addr=%h op=%0d got %h want %h", i, a, o, got, exp);
               end
            end
         end
         @(posedge clock);
         m_step();
         #1;
      end
      reset_in = 1'b0;
      idle_inputs();
   endtask

   initial begin
      reset_in = 1'b1;
      idle_inputs();
      test_reset();
      test_trap();
      test_mret();
      test_illegal();
      test_counters();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/msrv32_trap_csr_file.md
MSRV32_TRAP_CSR_FILE -- requirements
Module: msrv32_trap_csr_file

Interface
REQ-001 SHALL have one clock, `clock`; reset is `reset_in`, synchronous and active-high.
REQ-002 SHALL have these CSR access ports:
- csr_addr_in  in  12  CSR address
- csr_op_in  in  2  access op: 00 none, 01 write, 10 set, 11 clear
- csr_wdata_in  in  32  write/set/clear operand
- csr_data_out  out  32  read data
- illegal_csr_out  out  1  bad access flag
REQ-003 SHALL have these trap-control inputs from machine control:
- set_epc_in, set_cause_in, i_or_e_in, mie_clear_in, mie_set_in, instret_inc_in, misaligned_exception_in  in  1
- cause_in  in  4
REQ-004 SHALL have these datapath inputs:
- pc_in  in  32  PC of the faulting instruction
- iadder_in  in  32  faulting address
- e_irq_in, t_irq_in, s_irq_in  in  1  raw interrupt lines
REQ-005 SHALL have these outputs to machine control and the PC mux:
- mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out, msip_out  out  1
- epc_out  out  32
- trap_address_out  out  32

Function
REQ-006 SHALL implement these CSRs:
- mstatus 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] hardwired 11
- misa 0x301: reads 0x40000100
- mie 0x304: bits 11, 7, 3 writable
- mtvec 0x305
- mscratch 0x340
- mepc 0x341
- mcause 0x342
- mtval 0x343
- mip 0x344: read-only
- mvendorid, marchid, mimpid, mhartid 0xF11-0xF14: read 0
REQ-007 csr_data_out SHALL be combinational from csr_addr_in, with zero read latency.
REQ-008 Writes SHALL commit on the next clock edge. New value: op 01 = wdata; 10 = old | wdata; 11 = old & ~wdata. Unwritable bits keep their value.
REQ-009 illegal_csr_out SHALL assert combinationally when op≠00 and either the address is unimplemented or addr[11:10]=11. The write is then suppressed and csr_data_out=0.
REQ-010 A trap SHALL be taken on the edge where set_epc_in=1. On that edge:
- mepc <= {pc_in[31:2],2'b00}
- mtval <= misaligned_exception_in ? iadder_in : 0
REQ-011 When set_cause_in=1, mcause SHALL load {i_or_e_in, 27'b0, cause_in}.
REQ-012 When mie_clear_in=1: MPIE <= MIE and MIE <= 0.
REQ-013 When mie_set_in=1 (mret): MIE <= MPIE and MPIE <= 1.
REQ-014 A trap-control update SHALL override a same-cycle software write to the same CSR; the software write to that CSR is dropped.
REQ-015 mip.MEIP/MTIP/MSIP SHALL be registered copies of e_irq_in/t_irq_in/s_irq_in, updated every cycle. Writes to mip are ignored.
REQ-016 mtvec.MODE[1:0] SHALL be WARL: a written 00 or 01 is stored; 10 or 11 leaves MODE unchanged. The base is always written.
REQ-017 trap_address_out SHALL be combinational: mtvec base+4*mcause[3:0] when MODE=01 and mcause[31]=1; otherwise mtvec base with bits [1:0] zero.
REQ-018 epc_out SHALL equal mepc.
REQ-019 mie_out/meie_out/mtie_out/msie_out SHALL mirror mstatus.MIE and mie bits 11/7/3. meip_out/mtip_out/msip_out SHALL mirror mip.
REQ-020 Simultaneous mie_clear_in and mie_set_in SHALL be treated as mie_clear_in only.

Reset
REQ-021 On reset_in SHALL set:
- mstatus=0x00001800
- mie, mip, mtvec, mscratch, mepc, mcause, mtval = 0
- counters = 0
Outputs follow from these values; all outputs are 0 except csr_data_out, which is address-dependent.
REQ-022 Reset SHALL override all same-cycle traps, writes and increments.

Configuration
REQ-023 With MSRV32_COUNTERS_EN defined, SHALL implement 64-bit counters:
- mcycle 0xB00/0xB80: +1 every cycle
- minstret 0xB02/0xB82: +1 when instret_inc_in=1
- both wrap from 2^64-1 to 0
REQ-024 On a same-cycle software write to either 32-bit half of a counter, the write SHALL take precedence over that cycle's increment for the whole 64-bit counter.
REQ-025 Without MSRV32_COUNTERS_EN, addresses 0xB00/0xB80/0xB02/0xB82 SHALL be unimplemented (REQ-009 applies).

Structure
REQ-026 SHALL place these constants in the shared package msrv32_csr_pkg:
- CSR address constants
- csr_op encodings
- mstatus/mie/mip bit positions
- mtvec mode codes
- misa value
REQ-027 SHALL instantiate sub-module msrv32_csr_counter twice: 64-bit, with inc enable, and lo/hi write enables with data.

Verification
REQ-028 Reset, then read 0x300 -> 0x00001800; read 0x301 -> 0x40000100; all other CSRs read 0.
REQ-029 Trap: mie.MEIE=1, MIE=1, pc_in=0x00000106, set_epc/set_cause/mie_clear=1, i_or_e=1, cause=0xB → next cycle:
- mepc=0x00000104
- mcause=0x8000000B
- MIE=0, MPIE=1
- with mtvec=0x00001001: trap_address_out=0x0000102C
REQ-030 mie_set_in=1 after REQ-029 → MIE=1, MPIE=1. Same cycle: csr write 0x341=0x55 with set_epc_in=1 → mepc takes the trap value.
REQ-031 csr_op=01 to 0xF11 → illegal_csr_out=1, no state change; write 0x305 with value 0x00000203 → mtvec reads 0x00000200.
REQ-032 COUNTERS_EN: write mcycle=0xFFFFFFFF and mcycleh=0xFFFFFFFF → after 2 more cycles mcycle reads 0x00000001, mcycleh 0; instret_inc_in held 3 cycles → minstret=3.
